// File: rtl/pc_branch_unit.sv
// -----------------------------------------------------------------------------
// pc_branch_unit
//   Program-counter register with branch and jump resolution for the 16-bit
//   CPU. Evaluates the condition code against the flag register, selects the
//   next fetch address (displacement branch, register jump or sequential
//   increment) and captures the JAL return address.
//
// Ports
//   clk        in   1       system clock, all state changes on posedge
//   reset      in   1       synchronous, active-high; wins over every input
//   pc_en      in   1       update the PC this cycle
//   pc_mux_en  in   1       displacement branch (Bcond)
//   jump_en    in   1       register jump (Jcond/JAL); ignored when pc_mux_en=1
//   link_en    in   1       capture pc+1 into link_pc (needs pc_en=1)
//   cond       in   4       condition code
//   disp       in   8       two's-complement branch displacement
//   target     in   ADDR_W  register jump target
//   flags      in   8       [0]C [1]L [2]F [3]Z [4]N, bits [7:5] unused
//   pc         out  ADDR_W  current fetch address
//   link_pc    out  ADDR_W  captured return address
//   taken      out  1       one-cycle pulse after a taken branch/jump
// -----------------------------------------------------------------------------
module pc_branch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_en,
    input  logic              pc_mux_en,
    input  logic              jump_en,
    input  logic              link_en,
    input  logic [3:0]        cond,
    input  logic [7:0]        disp,
    input  logic [ADDR_W-1:0] target,
    input  logic [7:0]        flags,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link_pc,
    output logic              taken
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Condition evaluation; fl is {N, Z, F, L, C}.
    function automatic logic cond_met_f(input logic [3:0] cond_v, input logic [4:0] fl);
        logic c_v;
        logic l_v;
        logic f_v;
        logic z_v;
        logic n_v;
        c_v = fl[0];
        l_v = fl[1];
        f_v = fl[2];
        z_v = fl[3];
        n_v = fl[4];
        case (cond_v)
            4'h0:    cond_met_f = z_v;
            4'h1:    cond_met_f = ~z_v;
            4'h2:    cond_met_f = c_v;
            4'h3:    cond_met_f = ~c_v;
            4'h4:    cond_met_f = l_v;
            4'h5:    cond_met_f = ~l_v;
            4'h6:    cond_met_f = n_v;
            4'h7:    cond_met_f = ~n_v;
            4'h8:    cond_met_f = f_v;
            4'h9:    cond_met_f = ~f_v;
            4'hA:    cond_met_f = ~l_v & ~z_v;
            4'hB:    cond_met_f = l_v | z_v;
            4'hC:    cond_met_f = ~n_v & ~z_v;
            4'hD:    cond_met_f = n_v | z_v;
            4'hE:    cond_met_f = 1'b1;
            4'hF:    cond_met_f = 1'b0;
            default: cond_met_f = 1'b0;
        endcase
    endfunction

    // Replicate the displacement sign bit across the upper address bits.
    function automatic logic [ADDR_W-1:0] sext_f(input logic [7:0] d);
        sext_f = {{(ADDR_W-8){d[7]}}, d};
    endfunction

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] link_r;
    logic              taken_r;
    logic [ADDR_W-1:0] pc_next_s;
    logic [ADDR_W-1:0] link_next_s;
    logic              taken_next_s;
    logic [ADDR_W-1:0] pc_inc_s;
    logic              met_s;
    logic              unused_flags_s;

    assign pc_inc_s       = pc_r + PC_ONE;
    assign met_s          = cond_met_f(cond, flags[4:0]);
    assign unused_flags_s = ^flags[7:5];

    // Next-state selection: branch has priority over jump; a failed branch
    // falls through to pc+1 and never consults the jump target.
    always_comb begin
        pc_next_s    = pc_r;
        link_next_s  = link_r;
        taken_next_s = 1'b0;
        if (pc_en) begin
            if (pc_mux_en) begin
                if (met_s) begin
                    pc_next_s    = pc_r + sext_f(disp);
                    taken_next_s = 1'b1;
                end else begin
                    pc_next_s    = pc_inc_s;
                    taken_next_s = 1'b0;
                end
            end else if (jump_en && met_s) begin
                pc_next_s    = target;
                taken_next_s = 1'b1;
            end else begin
                pc_next_s    = pc_inc_s;
                taken_next_s = 1'b0;
            end
            // Return address is the pre-update pc+1, captured even if not taken.
            if (link_en) begin
                link_next_s = pc_inc_s;
            end else begin
                link_next_s = link_r;
            end
        end else begin
            pc_next_s    = pc_r;
            link_next_s  = link_r;
            taken_next_s = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r    <= RESET_PC;
            link_r  <= {ADDR_W{1'b0}};
            taken_r <= 1'b0;
        end else begin
            pc_r    <= pc_next_s;
            link_r  <= link_next_s;
            taken_r <= taken_next_s;
        end
    end

    assign pc      = pc_r;
    assign link_pc = link_r;
    assign taken   = taken_r;

endmodule

// File: tb/tb_pc_branch_unit.sv
module tb_pc_branch_unit;

    logic        clk;
    logic        reset;
    logic        pc_en;
    logic        pc_mux_en;
    logic        jump_en;
    logic        link_en;
    logic [3:0]  cond;
    logic [7:0]  disp;
    logic [15:0] target;
    logic [7:0]  flags;
    logic [15:0] pc;
    logic [15:0] link_pc;
    logic        taken;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic        en;
        logic        mux;
        logic        jmp;
        logic        lnk;
        logic        rst;
        logic [3:0]  cnd;
        logic [7:0]  dsp;
        logic [15:0] tgt;
        logic [7:0]  flg;
    } stim_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] link;
        logic        taken;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_pc   = 16'h0000;
    logic [15:0] m_link = 16'h0000;

    pc_branch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_en     (pc_en),
        .pc_mux_en (pc_mux_en),
        .jump_en   (jump_en),
        .link_en   (link_en),
        .cond      (cond),
        .disp      (disp),
        .target    (target),
        .flags     (flags),
        .pc        (pc),
        .link_pc   (link_pc),
        .taken     (taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference condition table, flags = {.., N, Z, F, L, C}.
    function automatic logic ref_met(input logic [3:0] c, input logic [7:0] f);
        logic cf, lf, ff, zf, nf;
        cf = f[0]; lf = f[1]; ff = f[2]; zf = f[3]; nf = f[4];
        case (c)
            4'h0: return zf;
            4'h1: return !zf;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return lf;
            4'h5: return !lf;
            4'h6: return nf;
            4'h7: return !nf;
            4'h8: return ff;
            4'h9: return !ff;
            4'hA: return !lf && !zf;
            4'hB: return lf || zf;
            4'hC: return !nf && !zf;
            4'hD: return nf || zf;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic stim_t mk(input logic en, input logic mux, input logic jmp,
                                 input logic lnk, input logic rst, input logic [3:0] cnd,
                                 input logic [7:0] dsp, input logic [15:0] tgt,
                                 input logic [7:0] flg);
        stim_t s;
        s.en = en; s.mux = mux; s.jmp = jmp; s.lnk = lnk; s.rst = rst;
        s.cnd = cnd; s.dsp = dsp; s.tgt = tgt; s.flg = flg;
        return s;
    endfunction

    // Common stimulus shapes.
    function automatic stim_t s_load(input logic [15:0] v);
        return mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hE, 8'h00, v, 8'h00);
    endfunction
    function automatic stim_t s_inc();
        return mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hE, 8'h00, 16'h0000, 8'h00);
    endfunction
    function automatic stim_t s_br(input logic [3:0] c, input logic [7:0] d, input logic [7:0] f);
        return mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, c, d, 16'h0000, f);
    endfunction
    function automatic stim_t s_jal(input logic [3:0] c, input logic [15:0] t);
        return mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, c, 8'h00, t, 8'h00);
    endfunction

    // Drive one cycle of stimulus and push the model's expected result.
    task automatic drive(input stim_t s);
        exp_t        e;
        logic [15:0] sx;
        reset = s.rst; pc_en = s.en; pc_mux_en = s.mux; jump_en = s.jmp;
        link_en = s.lnk; cond = s.cnd; disp = s.dsp; target = s.tgt; flags = s.flg;
        sx = {{8{s.dsp[7]}}, s.dsp};
        e.taken = 1'b0;
        if (s.rst) begin
            m_pc = 16'h0000; m_link = 16'h0000;
        end else if (s.en) begin
            if (s.lnk) m_link = m_pc + 16'h0001;
            if (s.mux) begin
                if (ref_met(s.cnd, s.flg)) begin m_pc = m_pc + sx; e.taken = 1'b1; end
                else m_pc = m_pc + 16'h0001;
            end else if (s.jmp && ref_met(s.cnd, s.flg)) begin
                m_pc = s.tgt; e.taken = 1'b1;
            end else begin
                m_pc = m_pc + 16'h0001;
            end
        end
        e.pc = m_pc;
        e.link = m_link;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        stim_t q[$];
        exp_t  e;
        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 16'h0000, 8'h00));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 16'h0000, 8'h00));
        q.push_back(s_inc()); q.push_back(s_inc()); q.push_back(s_inc());
        foreach (q[i]) begin
            drive(q[i]); @(posedge clk); #1;
            if (sb.size() == 0) begin checks++; $display("FAIL reset[%0d] scoreboard empty", i); end
            else begin
                e = sb.pop_front(); checks += 3;
                if (pc !== e.pc) $display("FAIL reset[%0d] pc got %h want %h", i, pc, e.pc); else passes++;
                if (link_pc !== e.link) $display("FAIL reset[%0d] link_pc got %h want %h", i, link_pc, e.link); else passes++;
                if (taken !== e.taken) $display("FAIL reset[%0d] taken got %b want %b", i, taken, e.taken); else passes++;
            end
        end
        checks++;
        if (pc !== 16'h0003) $display("FAIL reset_seq pc got %h want 0003", pc); else passes++;
    endtask

    task automatic test_branch();
        stim_t q[$];
        exp_t  e;
        q.push_back(s_load(16'h0010));
        q.push_back(s_br(4'hE, 8'hFC, 8'h00));                            // -> 000C
        q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hE, 8'h05, 16'h0000, 8'h00)); // hold, pulse ends
        q.push_back(s_br(4'hE, 8'h05, 8'h00));                            // -> 0011
        q.push_back(s_load(16'h0020));
        q.push_back(s_br(4'h0, 8'h10, 8'h00));                            // Z=0 -> 0021
        q.push_back(s_load(16'h0020));
        q.push_back(s_br(4'h0, 8'h10, 8'h08));                            // Z=1 -> 0030
        foreach (q[i]) begin
            drive(q[i]); @(posedge clk); #1;
            if (sb.size() == 0) begin checks++; $display("FAIL branch[%0d] scoreboard empty", i); end
            else begin
                e = sb.pop_front(); checks += 3;
                if (pc !== e.pc) $display("FAIL branch[%0d] pc got %h want %h", i, pc, e.pc); else passes++;
                if (link_pc !== e.link) $display("FAIL branch[%0d] link_pc got %h want %h", i, link_pc, e.link); else passes++;
                if (taken !== e.taken) $display("FAIL branch[%0d] taken got %b want %b", i, taken, e.taken); else passes++;
            end
        end
    endtask

    task automatic test_cond_table();
        exp_t  e;
        stim_t s;
        logic [2:0] junk;
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 32; f++) begin
                for (int p = 0; p < 2; p++) begin
                    junk = 3'($urandom_range(7, 0));
                    s = mk(1'b1, (p == 0), (p == 1), 1'b0, 1'b0, 4'(c), 8'(8'hF6 + f),
                           16'(16'h4000 + c * 64 + f), {junk, 5'(f)});
                    drive(s); @(posedge clk); #1;
                    if (sb.size() == 0) begin checks++; $display("FAIL cond c=%0d f=%0d scoreboard empty", c, f); end
                    else begin
                        e = sb.pop_front(); checks += 2;
                        if (pc !== e.pc) $display("FAIL cond c=%0d f=%0d p=%0d pc got %h want %h", c, f, p, pc, e.pc); else passes++;
                        if (taken !== e.taken) $display("FAIL cond c=%0d f=%0d p=%0d taken got %b want %b", c, f, p, taken, e.taken); else passes++;
                    end
                end
            end
        end
    endtask

    task automatic test_jump_link();
        stim_t q[$];
        exp_t  e;
        q.push_back(s_load(16'h0030));
        q.push_back(s_jal(4'hE, 16'h1234));                               // pc 1234, link 0031
        q.push_back(s_load(16'h0030));
        q.push_back(s_jal(4'hF, 16'h1234));                               // pc 0031, link 0031
        q.push_back(s_load(16'h0050));
        q.push_back(s_jal(4'hF, 16'h1234));                               // link 0051 though not taken
        q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hE, 8'h00, 16'h7777, 8'h00)); // pc_en=0: no effect
        foreach (q[i]) begin
            drive(q[i]); @(posedge clk); #1;
            if (sb.size() == 0) begin checks++; $display("FAIL jal[%0d] scoreboard empty", i); end
            else begin
                e = sb.pop_front(); checks += 3;
                if (pc !== e.pc) $display("FAIL jal[%0d] pc got %h want %h", i, pc, e.pc); else passes++;
                if (link_pc !== e.link) $display("FAIL jal[%0d] link_pc got %h want %h", i, link_pc, e.link); else passes++;
                if (taken !== e.taken) $display("FAIL jal[%0d] taken got %b want %b", i, taken, e.taken); else passes++;
            end
        end
    endtask

    task automatic test_wrap();
        stim_t q[$];
        exp_t  e;
        q.push_back(s_load(16'hFFFF));
        q.push_back(s_inc());                                             // -> 0000
        q.push_back(s_load(16'h0002));
        q.push_back(s_br(4'hE, 8'h80, 8'h00));                            // -> FF82
        q.push_back(s_br(4'hE, 8'h7F, 8'h00));                            // -> 0001 (wrap up)
        foreach (q[i]) begin
            drive(q[i]); @(posedge clk); #1;
            if (sb.size() == 0) begin checks++; $display("FAIL wrap[%0d] scoreboard empty", i); end
            else begin
                e = sb.pop_front(); checks += 2;
                if (pc !== e.pc) $display("FAIL wrap[%0d] pc got %h want %h", i, pc, e.pc); else passes++;
                if (taken !== e.taken) $display("FAIL wrap[%0d] taken got %b want %b", i, taken, e.taken); else passes++;
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t q[$];
        exp_t  e;
        q.push_back(s_load(16'h0100));
        q.push_back(s_br(4'hE, 8'h01, 8'h00));
        q.push_back(s_br(4'hE, 8'h01, 8'h00));
        q.push_back(s_inc());
        foreach (q[i]) begin
            drive(q[i]); @(posedge clk); #1;
            if (sb.size() == 0) begin checks++; $display("FAIL b2b[%0d] scoreboard empty", i); end
            else begin
                e = sb.pop_front(); checks += 2;
                if (pc !== e.pc) $display("FAIL b2b[%0d] pc got %h want %h", i, pc, e.pc); else passes++;
                if (taken !== e.taken) $display("FAIL b2b[%0d] taken got %b want %b", i, taken, e.taken); else passes++;
            end
        end
    endtask

    task automatic test_priority_reset();
        stim_t q[$];
        exp_t  e;
        q.push_back(s_load(16'h0040));
        q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hE, 8'h02, 16'h9999, 8'h00)); // -> 0042
        q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 8'h02, 16'h9999, 8'h00)); // -> 0043
        q.push_back(s_jal(4'hE, 16'h2222));                                         // link 0044
        q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'hE, 8'h00, 16'h5555, 8'h00)); // reset wins
        q.push_back(s_inc());
        foreach (q[i]) begin
            drive(q[i]); @(posedge clk); #1;
            if (sb.size() == 0) begin checks++; $display("FAIL prio[%0d] scoreboard empty", i); end
            else begin
                e = sb.pop_front(); checks += 3;
                if (pc !== e.pc) $display("FAIL prio[%0d] pc got %h want %h", i, pc, e.pc); else passes++;
                if (link_pc !== e.link) $display("FAIL prio[%0d] link_pc got %h want %h", i, link_pc, e.link); else passes++;
                if (taken !== e.taken) $display("FAIL prio[%0d] taken got %b want %b", i, taken, e.taken); else passes++;
            end
        end
    endtask

    initial begin
        reset = 1'b1; pc_en = 1'b0; pc_mux_en = 1'b0; jump_en = 1'b0; link_en = 1'b0;
        cond = 4'h0; disp = 8'h00; target = 16'h0000; flags = 8'h00;
        test_reset();
        test_branch();
        test_jump_link();
        test_wrap();
        test_back_to_back();
        test_priority_reset();
        test_cond_table();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
